// File: rtl/hazard_pkg.sv
// Shared types for pipeline hazard control: controller FSM states and the
// per-register {en, flush} pair consumed by the datapath register wrappers.
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    IWAIT = 2'd2,
    DWAIT = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_RUN    = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctrl_t STAGE_FREEZE = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctrl_t STAGE_BUBBLE = '{en: 1'b0, flush: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall/flush controller: turns hazard, cache-miss and branch
// requests into per-stage enable/bubble controls, with miss watchdog and counters.
module pipeline_control
  import hazard_pkg::*;
#(
  parameter int unsigned MISS_TIMEOUT = 256,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned TO_W         = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             icache_miss,
  input  logic             icache_ready,
  input  logic             dcache_miss,
  input  logic             dcache_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             icache_abort,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MISS_TIMEOUT);

  ctrl_state_t state_q, state_d;
  stage_ctrl_t if_id_c, id_ex_c, ex_mem_c, mem_wb_c;
  logic        pc_en_c, abort_c, redirect_c;

  logic [TO_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            in_wait;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT: state_d = RUN;
      RUN: begin
        if (dcache_miss)                             state_d = DWAIT;
        else if (!branch_taken && !load_use_stall &&
                 icache_miss)                        state_d = IWAIT;
      end
      IWAIT: begin
        if (dcache_miss)                             state_d = DWAIT;
        else if (branch_taken)                       state_d = RUN;
        else if (!load_use_stall && icache_ready)    state_d = RUN;
      end
      DWAIT: begin
        if (dcache_ready)                            state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  // Control outputs: flush always wins over en at the consuming register
  always_comb begin
    pc_en_c    = 1'b1;
    if_id_c    = STAGE_RUN;
    id_ex_c    = STAGE_RUN;
    ex_mem_c   = STAGE_RUN;
    mem_wb_c   = STAGE_RUN;
    abort_c    = 1'b0;
    redirect_c = 1'b0;
    unique case (state_q)
      INIT: begin
        pc_en_c  = 1'b0;
        if_id_c  = STAGE_BUBBLE;
        id_ex_c  = STAGE_BUBBLE;
        ex_mem_c = STAGE_BUBBLE;
        mem_wb_c = STAGE_BUBBLE;
      end
      RUN: begin
        if (dcache_miss) begin
          pc_en_c        = 1'b0;
          if_id_c        = STAGE_FREEZE;
          id_ex_c        = STAGE_FREEZE;
          ex_mem_c       = STAGE_FREEZE;
          mem_wb_c.flush = 1'b1;
        end else if (branch_taken) begin
          if_id_c.flush = 1'b1;
          id_ex_c.flush = 1'b1;
          abort_c       = icache_miss;
          redirect_c    = 1'b1;
        end else if (load_use_stall) begin
          pc_en_c        = 1'b0;
          if_id_c        = STAGE_FREEZE;
          id_ex_c        = STAGE_FREEZE;
          ex_mem_c.flush = 1'b1;
        end else if (icache_miss) begin
          pc_en_c       = 1'b0;
          if_id_c.flush = 1'b1;
        end
      end
      IWAIT: begin
        pc_en_c       = 1'b0;
        if_id_c.flush = 1'b1;
        if (dcache_miss) begin
          if_id_c        = STAGE_FREEZE;
          id_ex_c        = STAGE_FREEZE;
          ex_mem_c       = STAGE_FREEZE;
          mem_wb_c.flush = 1'b1;
        end else if (branch_taken) begin
          pc_en_c       = 1'b1;
          id_ex_c.flush = 1'b1;
          abort_c       = 1'b1;
          redirect_c    = 1'b1;
        end else if (load_use_stall) begin
          id_ex_c.en     = 1'b0;
          ex_mem_c.flush = 1'b1;
        end else if (icache_ready) begin
          pc_en_c       = 1'b1;
          if_id_c.flush = 1'b0;
        end
      end
      DWAIT: begin
        // The fill-complete cycle releases everything immediately
        if (!dcache_ready) begin
          pc_en_c        = 1'b0;
          if_id_c        = STAGE_FREEZE;
          id_ex_c        = STAGE_FREEZE;
          ex_mem_c       = STAGE_FREEZE;
          mem_wb_c.flush = 1'b1;
        end
      end
      default: begin
        pc_en_c = 1'b0;
      end
    endcase
  end

  assign pc_en        = pc_en_c;
  assign if_id_en     = if_id_c.en;
  assign if_id_flush  = if_id_c.flush;
  assign id_ex_en     = id_ex_c.en;
  assign id_ex_flush  = id_ex_c.flush;
  assign ex_mem_en    = ex_mem_c.en;
  assign ex_mem_flush = ex_mem_c.flush;
  assign mem_wb_en    = mem_wb_c.en;
  assign mem_wb_flush = mem_wb_c.flush;
  assign icache_abort = abort_c;

  // Watchdog counter parks at the limit so it never wraps during a long hang
  always_comb begin
    in_wait   = (state_q == IWAIT) || (state_q == DWAIT);
    wd_d      = '0;
    timeout_d = timeout_q;
    if (in_wait) begin
      wd_d = (wd_q == TO_LIMIT) ? wd_q : wd_q + 1'b1;
      if (wd_d == TO_LIMIT) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q != INIT) && !pc_en_c),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect_c),
    .clr   (1'b0),
    .count (flush_count)
  );

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Consumes stall/flush requests from the load-use hazard detector, the I/D caches and EX-stage branch resolution.
- Produces per-stage enable (hold) and flush (bubble-insert) controls for the PC and the four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Tracks multi-cycle cache-miss stalls with a small FSM.
- Provides a miss watchdog and saturating performance counters.

Parameters:
- MISS_TIMEOUT, 256: consecutive wait cycles before timeout_err is raised.
- CNT_W, 32: width of the performance counters.
- TO_W, 9: width of the watchdog counter; must hold MISS_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- load_use_stall  in  1  hazard detector: instruction in EX depends on a LW in MEM
- branch_taken  in  1  EX redirect (taken branch/JAL/JALR mispredict)
- icache_miss  in  1  level; fetch miss outstanding
- icache_ready  in  1  pulse; fetch fill complete
- dcache_miss  in  1  level; MEM-stage miss outstanding
- dcache_ready  in  1  pulse; data fill complete
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads NOP bubble
- id_ex_en  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads bubble
- ex_mem_en  out  1  EX/MEM load enable
- ex_mem_flush  out  1  EX/MEM loads bubble
- mem_wb_en  out  1  MEM/WB load enable
- mem_wb_flush  out  1  MEM/WB loads bubble
- icache_abort  out  1  cancel outstanding fetch miss
- timeout_err  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0
- flush_count  out  CNT_W  saturating count of branch redirects

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low on rst_n; clock port is clk, reset port is rst_n.
  - On reset the FSM enters INIT; counters, watchdog and timeout_err are cleared to 0.
- Control outputs:
  - All control outputs are combinational from FSM state plus inputs.
  - Flush has precedence over enable for the same register: a flushed register loads the bubble regardless of its en.
- FSM states: INIT, RUN, IWAIT, DWAIT.
  - Reset mid-operation returns to INIT immediately, from any state.
- INIT:
  - All en=0, all flush=1, icache_abort=0.
  - Always advances to RUN on the next edge.
- RUN. Default is all en=1, all flush=0. Priority per cycle, highest first:
  1. dcache_miss: pc/if_id/id_ex/ex_mem en=0; mem_wb_flush=1. Next state DWAIT.
  2. branch_taken: pc_en=1; if_id_flush=1; id_ex_flush=1. If icache_miss is also high, icache_abort=1. Stay in RUN.
  3. load_use_stall: pc/if_id/id_ex en=0; ex_mem_flush=1. Single cycle; stay in RUN.
  4. icache_miss: pc_en=0, if_id_flush=1, downstream flows. Next state IWAIT.
- IWAIT. Baseline is pc_en=0 and if_id_flush=1; downstream stages flow.
  - dcache_miss: apply the DWAIT control, go to DWAIT.
  - Else branch_taken: icache_abort=1, redirect as in RUN, go to RUN.
  - Else load_use_stall: id_ex_en=0, ex_mem_flush=1, stay in IWAIT.
  - Else icache_ready: pc_en=1, if_id_flush=0, go to RUN.
  - icache_ready and branch_taken in the same cycle: the branch wins and icache_abort=1.
- DWAIT:
  - Freeze pc/if_id/id_ex/ex_mem; mem_wb_flush=1 every cycle.
  - dcache_ready: release in that same cycle (all en=1, no flush), go to RUN.
  - branch_taken and load_use_stall are ignored while in DWAIT; EX is frozen, so they are re-presented after release.
  - icache_miss is re-sampled in RUN.
- Watchdog:
  - Counter increments each cycle in IWAIT/DWAIT and clears on any other state.
  - On reaching MISS_TIMEOUT, timeout_err is set and held until reset.
  - The FSM keeps waiting after timeout_err is set.
- Counters:
  - stall_cycles +1 per cycle with pc_en=0 outside INIT.
  - flush_count +1 per cycle in which a branch redirect is applied.
  - Both saturate at all-ones; no wrap.

Decomposition:
- Shared package hazard_pkg holds:
  - ctrl_state_t enum (INIT, RUN, IWAIT, DWAIT).
  - stage_ctrl_t packed struct of {en, flush} per register, used by datapath register wrappers.
- One sub-module, sat_counter (parameter W, inputs inc/clr, async active-low reset), instantiated twice for the performance counters.

Test Plan:
- Reset release: rst_n low→high → INIT: all en=0, flush=1 for one cycle; then RUN: all en=1, flush=0.
- Load-use: load_use_stall=1 for one cycle in RUN → pc/if_id/id_ex en=0, ex_mem_flush=1 that cycle; stall_cycles=1; next cycle normal.
- D-miss: dcache_miss held 5 cycles, dcache_ready on cycle 5 → freeze plus mem_wb_flush for cycles 1-4, release on cycle 5; stall_cycles=4. branch_taken pulsed mid-wait → flush_count stays 0.
- I-miss with redirect: icache_miss in RUN, branch_taken 3 cycles later → icache_abort=1, if_id_flush=1, id_ex_flush=1, pc_en=1, state RUN, flush_count=1.
- Nested: in IWAIT, dcache_miss=1 → DWAIT control. After dcache_ready with icache_miss still high → IWAIT re-entered next cycle.
- Watchdog: MISS_TIMEOUT=8, dcache_miss held with no ready → timeout_err rises after 8 wait cycles and stays 1 after ready. Also assert rst_n low mid-DWAIT → immediate INIT, timeout_err=0, counters=0.
